// File: rtl/bottleneck_seq.sv
// Bridges a 64-bit master port onto a 16- or 32-bit slave port, splitting wide
// accesses into little-endian beats and assembling read data before the master ack.
//
// state | meaning
// IDLE  | no access partway through; the next slave beat is beat 0 (k = 0)
// BEAT  | multi-beat access partway through; k_q holds the next beat index (k > 0)
module bottleneck_seq #(
    parameter int SLAVE_WIDTH = 16,
    parameter int ADR_WIDTH   = 64
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [ADR_WIDTH-1:0]              m_adr_i,
    input  logic                              m_cyc_i,
    input  logic [63:0]                       m_dat_i,
    input  logic                              m_signed_i,
    input  logic [1:0]                        m_siz_i,
    input  logic                              m_stb_i,
    input  logic                              m_we_i,
    output logic                              m_ack_o,
    output logic [63:0]                       m_dat_o,
    output logic [ADR_WIDTH-1:0]              s_adr_o,
    output logic                              s_cyc_o,
    output logic [SLAVE_WIDTH-1:0]            s_dat_o,
    output logic                              s_signed_o,
    output logic [$clog2(SLAVE_WIDTH/8)-1:0]  s_siz_o,
    output logic                              s_stb_o,
    output logic                              s_we_o,
    input  logic                              s_ack_i,
    input  logic [SLAVE_WIDTH-1:0]            s_dat_i
);
    localparam int BYTES_PER_BEAT = SLAVE_WIDTH / 8;
    localparam int BEAT_SIZ       = $clog2(BYTES_PER_BEAT);
    localparam int SIZ_W          = BEAT_SIZ;
    localparam int MAX_BEATS      = 64 / SLAVE_WIDTH;
    localparam int K_W            = $clog2(MAX_BEATS);

    typedef enum logic {IDLE, BEAT} state_t;

    state_t         state_q, state_d;
    logic [K_W-1:0] k_q, k_d, k_cur, last_k;
    logic [63:0]    h_q, h_d, assembled;
    logic           stb, beat_done;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            k_q     <= '0;
            h_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            h_q     <= h_d;
        end
    end

    always_comb begin
        k_cur     = (state_q == BEAT) ? k_q : '0;
        stb       = m_stb_i & m_cyc_i & ~reset_i;
        beat_done = stb & s_ack_i;

        if (int'(m_siz_i) <= BEAT_SIZ) begin
            last_k = '0;
        end else begin
            last_k = K_W'((1 << (int'(m_siz_i) - BEAT_SIZ)) - 1);
        end

        k_d = k_cur;
        h_d = h_q;
        if (!(m_cyc_i && m_stb_i)) begin
            k_d = '0;
        end else if (beat_done) begin
            if (k_cur < last_k) begin
                for (int i = 0; i < MAX_BEATS; i++) begin
                    if (i == int'(k_cur)) begin
                        h_d[i*SLAVE_WIDTH +: SLAVE_WIDTH] = s_dat_i;
                    end
                end
                k_d = k_cur + K_W'(1);
            end else begin
                k_d = '0;
            end
        end
        state_d = (k_d == '0) ? IDLE : BEAT;
    end

    // The final slice comes straight from the slave so the ack adds no latency.
    always_comb begin
        assembled = h_q;
        s_dat_o   = m_dat_i[SLAVE_WIDTH-1:0];
        for (int i = 0; i < MAX_BEATS; i++) begin
            if (i == int'(k_cur)) begin
                assembled[i*SLAVE_WIDTH +: SLAVE_WIDTH] = s_dat_i;
                s_dat_o = m_dat_i[i*SLAVE_WIDTH +: SLAVE_WIDTH];
            end
        end

        case (m_siz_i)
            2'b00:   m_dat_o = {{56{m_signed_i & assembled[7]}},  assembled[7:0]};
            2'b01:   m_dat_o = {{48{m_signed_i & assembled[15]}}, assembled[15:0]};
            2'b10:   m_dat_o = {{32{m_signed_i & assembled[31]}}, assembled[31:0]};
            default: m_dat_o = assembled;
        endcase

        m_ack_o = beat_done & (k_cur == last_k);
        s_siz_o = (int'(m_siz_i) <= BEAT_SIZ) ? m_siz_i[SIZ_W-1:0] : SIZ_W'(BEAT_SIZ);
    end

    assign s_cyc_o    = m_cyc_i & ~reset_i;
    assign s_stb_o    = stb;
    assign s_signed_o = m_signed_i;
    assign s_we_o     = m_we_i;
    assign s_adr_o    = m_adr_i + (ADR_WIDTH'(k_cur) << BEAT_SIZ);

endmodule

// File: tb/tb_bottleneck_seq.sv
// Directed bench for bottleneck_seq: a 16-bit and a 32-bit slave instance share
// the master port, each with its own slave-side stimulus.
module tb_bottleneck_seq;
    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [63:0] m_adr_i;
    logic        m_cyc_i;
    logic [63:0] m_dat_i;
    logic        m_signed_i;
    logic [1:0]  m_siz_i;
    logic        m_stb_i;
    logic        m_we_i;

    logic        m_ack_16, s_cyc_16, s_signed_16, s_stb_16, s_we_16, s_ack_16;
    logic [63:0] m_dat_16, s_adr_16;
    logic [15:0] s_dat_o_16, s_dat_i_16;
    logic [0:0]  s_siz_16;

    logic        m_ack_32, s_cyc_32, s_signed_32, s_stb_32, s_we_32, s_ack_32;
    logic [63:0] m_dat_32, s_adr_32;
    logic [31:0] s_dat_o_32, s_dat_i_32;
    logic [1:0]  s_siz_32;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    bottleneck_seq #(.SLAVE_WIDTH(16), .ADR_WIDTH(64)) dut16 (
        .clk_i(clk_i), .reset_i(reset_i),
        .m_adr_i(m_adr_i), .m_cyc_i(m_cyc_i), .m_dat_i(m_dat_i),
        .m_signed_i(m_signed_i), .m_siz_i(m_siz_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_ack_o(m_ack_16), .m_dat_o(m_dat_16),
        .s_adr_o(s_adr_16), .s_cyc_o(s_cyc_16), .s_dat_o(s_dat_o_16),
        .s_signed_o(s_signed_16), .s_siz_o(s_siz_16), .s_stb_o(s_stb_16), .s_we_o(s_we_16),
        .s_ack_i(s_ack_16), .s_dat_i(s_dat_i_16)
    );

    bottleneck_seq #(.SLAVE_WIDTH(32), .ADR_WIDTH(64)) dut32 (
        .clk_i(clk_i), .reset_i(reset_i),
        .m_adr_i(m_adr_i), .m_cyc_i(m_cyc_i), .m_dat_i(m_dat_i),
        .m_signed_i(m_signed_i), .m_siz_i(m_siz_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_ack_o(m_ack_32), .m_dat_o(m_dat_32),
        .s_adr_o(s_adr_32), .s_cyc_o(s_cyc_32), .s_dat_o(s_dat_o_32),
        .s_signed_o(s_signed_32), .s_siz_o(s_siz_32), .s_stb_o(s_stb_32), .s_we_o(s_we_32),
        .s_ack_i(s_ack_32), .s_dat_i(s_dat_i_32)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1ns later.
    task automatic next_cycle();
        @(negedge clk_i);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic go_idle();
        next_cycle();
        m_stb_i  = 1'b0;
        s_ack_16 = 1'b0;
        s_ack_32 = 1'b0;
        settle();
        chk("idle_ack16", m_ack_16, 1'b0);
    endtask

    logic [15:0] wr_beats [4];

    initial begin
        reset_i    = 1'b1;
        m_adr_i    = '0;
        m_cyc_i    = 1'b1;
        m_dat_i    = '0;
        m_signed_i = 1'b0;
        m_siz_i    = 2'b00;
        m_stb_i    = 1'b1;
        m_we_i     = 1'b0;
        s_ack_16   = 1'b1;
        s_dat_i_16 = '0;
        s_ack_32   = 1'b1;
        s_dat_i_32 = '0;
        wr_beats[0] = 16'hDDDD;
        wr_beats[1] = 16'hCCCC;
        wr_beats[2] = 16'hBBBB;
        wr_beats[3] = 16'hAAAA;

        // Reset forces slave strobe/cycle and master ack low
        next_cycle();
        settle();
        chk("rst_stb16", s_stb_16, 1'b0);
        chk("rst_cyc16", s_cyc_16, 1'b0);
        chk("rst_ack16", m_ack_16, 1'b0);
        chk("rst_ack32", m_ack_32, 1'b0);
        next_cycle();
        reset_i  = 1'b0;
        m_stb_i  = 1'b0;
        s_ack_16 = 1'b0;
        s_ack_32 = 1'b0;
        settle();
        chk("post_rst_adr16", s_adr_16, 64'h0);

        // 1: byte read with one wait state, signed then unsigned
        next_cycle();
        m_adr_i    = 64'h4444_3333_2222_1111;
        m_siz_i    = 2'b00;
        m_signed_i = 1'b1;
        m_stb_i    = 1'b1;
        s_dat_i_16 = 16'h00AA;
        settle();
        chk("t1_wait_ack", m_ack_16, 1'b0);
        chk("t1_adr", s_adr_16, 64'h4444_3333_2222_1111);
        chk("t1_siz", s_siz_16, 1'b0);
        chk("t1_stb", s_stb_16, 1'b1);
        next_cycle();
        s_ack_16 = 1'b1;
        settle();
        chk("t1_ack", m_ack_16, 1'b1);
        chk("t1_dat_signed", m_dat_16, 64'hFFFF_FFFF_FFFF_FFAA);
        next_cycle();
        m_signed_i = 1'b0;
        settle();
        chk("t1_dat_unsigned", m_dat_16, 64'h0000_0000_0000_00AA);
        chk("t1_signed_copy", s_signed_16, 1'b0);
        go_idle();

        // 2: word read, two beats, signed then unsigned
        next_cycle();
        m_adr_i    = 64'h1000;
        m_siz_i    = 2'b10;
        m_signed_i = 1'b1;
        m_stb_i    = 1'b1;
        s_ack_16   = 1'b1;
        s_dat_i_16 = 16'h5678;
        settle();
        chk("t2_adr0", s_adr_16, 64'h1000);
        chk("t2_siz", s_siz_16, 1'b1);
        chk("t2_ack0", m_ack_16, 1'b0);
        next_cycle();
        s_dat_i_16 = 16'h8765;
        settle();
        chk("t2_adr1", s_adr_16, 64'h1002);
        chk("t2_ack1", m_ack_16, 1'b1);
        chk("t2_dat_signed", m_dat_16, 64'hFFFF_FFFF_8765_5678);
        go_idle();
        next_cycle();
        m_signed_i = 1'b0;
        m_stb_i    = 1'b1;
        s_ack_16   = 1'b1;
        s_dat_i_16 = 16'h5678;
        settle();
        chk("t2u_ack0", m_ack_16, 1'b0);
        next_cycle();
        s_dat_i_16 = 16'h8765;
        settle();
        chk("t2u_ack1", m_ack_16, 1'b1);
        chk("t2_dat_unsigned", m_dat_16, 64'h0000_0000_8765_5678);
        go_idle();

        // 3: dword write, ack every cycle
        next_cycle();
        m_adr_i  = 64'h2000;
        m_siz_i  = 2'b11;
        m_we_i   = 1'b1;
        m_dat_i  = 64'hAAAA_BBBB_CCCC_DDDD;
        m_stb_i  = 1'b1;
        s_ack_16 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) next_cycle();
            settle();
            chk("t3_dat", s_dat_o_16, wr_beats[i]);
            chk("t3_adr", s_adr_16, 64'h2000 + 64'(2 * i));
            chk("t3_we", s_we_16, 1'b1);
            chk("t3_ack", m_ack_16, (i == 3) ? 1'b1 : 1'b0);
        end
        go_idle();

        // 4: dword read interrupted by reset after two beats, then full restart
        next_cycle();
        m_we_i     = 1'b0;
        m_adr_i    = 64'h5000;
        m_siz_i    = 2'b11;
        m_signed_i = 1'b0;
        m_stb_i    = 1'b1;
        s_ack_16   = 1'b1;
        s_dat_i_16 = 16'h0123;
        settle();
        chk("t4_adr0", s_adr_16, 64'h5000);
        next_cycle();
        s_dat_i_16 = 16'h4567;
        settle();
        chk("t4_adr1", s_adr_16, 64'h5002);
        next_cycle();
        reset_i = 1'b1;
        settle();
        chk("t4_rst_stb", s_stb_16, 1'b0);
        chk("t4_rst_ack", m_ack_16, 1'b0);
        next_cycle();
        reset_i    = 1'b0;
        s_dat_i_16 = 16'h0123;
        settle();
        chk("t4_restart_adr", s_adr_16, 64'h5000);
        chk("t4_restart_ack", m_ack_16, 1'b0);
        next_cycle();
        s_dat_i_16 = 16'h4567;
        settle();
        chk("t4_b1_adr", s_adr_16, 64'h5002);
        next_cycle();
        s_ack_16   = 1'b0;
        s_dat_i_16 = 16'h89AB;
        settle();
        chk("t4_wait_adr", s_adr_16, 64'h5004);
        chk("t4_wait_ack", m_ack_16, 1'b0);
        next_cycle();
        s_ack_16 = 1'b1;
        settle();
        chk("t4_b2_adr", s_adr_16, 64'h5004);
        next_cycle();
        s_dat_i_16 = 16'hCDEF;
        settle();
        chk("t4_b3_adr", s_adr_16, 64'h5006);
        chk("t4_ack", m_ack_16, 1'b1);
        chk("t4_dat", m_dat_16, 64'hCDEF_89AB_4567_0123);
        go_idle();

        // 5: 32-bit slave, dword read in two beats
        next_cycle();
        m_adr_i    = 64'h3000;
        m_siz_i    = 2'b11;
        m_stb_i    = 1'b1;
        s_ack_32   = 1'b1;
        s_dat_i_32 = 32'h1111_2222;
        settle();
        chk("t5_adr0", s_adr_32, 64'h3000);
        chk("t5_siz", s_siz_32, 2'd2);
        chk("t5_ack0", m_ack_32, 1'b0);
        chk("t5_idle16_adr", s_adr_16, 64'h3000);
        next_cycle();
        s_dat_i_32 = 32'h3333_4444;
        settle();
        chk("t5_adr1", s_adr_32, 64'h3004);
        chk("t5_ack1", m_ack_32, 1'b1);
        chk("t5_dat", m_dat_32, 64'h3333_4444_1111_2222);
        go_idle();

        // 32-bit slave: single-beat half read (signed) and byte write
        next_cycle();
        m_adr_i    = 64'h3102;
        m_siz_i    = 2'b01;
        m_signed_i = 1'b1;
        m_stb_i    = 1'b1;
        s_ack_32   = 1'b1;
        s_dat_i_32 = 32'h0000_8001;
        settle();
        chk("t5h_siz", s_siz_32, 2'd1);
        chk("t5h_ack", m_ack_32, 1'b1);
        chk("t5h_dat", m_dat_32, 64'hFFFF_FFFF_FFFF_8001);
        next_cycle();
        m_siz_i = 2'b00;
        m_we_i  = 1'b1;
        m_dat_i = 64'h0000_0000_0000_00DD;
        settle();
        chk("t5b_sdat", s_dat_o_32, 32'h0000_00DD);
        chk("t5b_ack", m_ack_32, 1'b1);
        go_idle();

        // 6: word read aborted after beat 1, then re-issued
        next_cycle();
        m_we_i     = 1'b0;
        m_signed_i = 1'b0;
        m_adr_i    = 64'h6000;
        m_siz_i    = 2'b10;
        m_stb_i    = 1'b1;
        s_ack_16   = 1'b1;
        s_dat_i_16 = 16'h1234;
        settle();
        chk("t6_adr0", s_adr_16, 64'h6000);
        chk("t6_ack0", m_ack_16, 1'b0);
        next_cycle();
        m_stb_i = 1'b0;
        settle();
        chk("t6_abort_stb", s_stb_16, 1'b0);
        chk("t6_abort_ack", m_ack_16, 1'b0);
        next_cycle();
        m_stb_i  = 1'b1;
        s_ack_16 = 1'b0;
        settle();
        chk("t6_reissue_adr", s_adr_16, 64'h6000);
        chk("t6_reissue_ack", m_ack_16, 1'b0);
        next_cycle();
        s_ack_16 = 1'b1;
        settle();
        chk("t6_b0_ack", m_ack_16, 1'b0);
        next_cycle();
        s_dat_i_16 = 16'hBEEF;
        settle();
        chk("t6_b1_adr", s_adr_16, 64'h6002);
        chk("t6_ack", m_ack_16, 1'b1);
        chk("t6_dat", m_dat_16, 64'h0000_0000_BEEF_1234);
        go_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
